// File: rtl/xm23_bcd_pkg.sv
// Shared types and helpers for the XM23 multi-precision BCD datapath.
package xm23_bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } seq_state_t;

    // Bit positions of the flags inside the PSW word
    localparam int PSW_C = 0;
    localparam int PSW_Z = 1;

    // Per-digit 9's complement; non-BCD digits wrap modulo 16
    function automatic logic [15:0] bcd9comp(input logic [15:0] v);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'd9 - v[4*i +: 4];
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_word_add.sv
// Combinational 4-digit BCD word adder with digit carry rippling LS to MS.
module bcd_word_add (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout
);

    logic [4:0] dsum;
    logic [4:0] dadj;
    logic       c_v;

    // Digit-serial decimal add; sums above 9 are corrected by +6 and carry out
    always_comb begin
        sum  = '0;
        c_v  = cin;
        dsum = '0;
        dadj = '0;
        for (int i = 0; i < 4; i++) begin
            dsum = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]} + {4'b0, c_v};
            dadj = dsum + 5'd6;
            if (dsum > 5'd9) begin
                sum[4*i +: 4] = dadj[3:0];
                c_v           = 1'b1;
            end else begin
                sum[4*i +: 4] = dsum[3:0];
                c_v           = 1'b0;
            end
        end
        cout = c_v;
    end

endmodule

// File: rtl/bcd_mp_sequencer.sv
// Multi-precision BCD add/subtract sequencer: one command, then LS-first
// operand word pairs; result words stream out and final C/Z go to the PSW.
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high
// RUN   | accepting operand pairs, one result word per pair
// DRAIN | all pairs taken, waiting for the final result word to be consumed
// FIN   | one-cycle completion: done pulse, flags presented on psw_out/psw_msk
module bcd_mp_sequencer
    import xm23_bcd_pkg::*;
#(
    parameter int MAX_WORDS = 8,
    parameter int LEN_W     = $clog2(MAX_WORDS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             cmd_sub,
    input  logic             cmd_cin,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [15:0]      op_a,
    input  logic [15:0]      op_b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [15:0]      res_data,
    output logic             res_last,
    output logic             busy,
    output logic             done,
    output logic [15:0]      psw_out,
    output logic [15:0]      psw_msk
);

    seq_state_t       state_q, state_d;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] cnt_q;
    logic             sub_q;
    logic             carry_q;
    logic             zacc_q;
    logic [15:0]      res_data_q;
    logic             res_valid_q;
    logic             res_last_q;
    logic [1:0]       psw_q;

    logic [15:0]      add_b;
    logic [15:0]      add_sum;
    logic             add_cout;
    logic             cmd_fire;
    logic             op_fire;
    logic             res_fire;
    logic             last_pair;

    assign add_b     = sub_q ? bcd9comp(op_b) : op_b;
    assign cmd_fire  = cmd_valid && (state_q == IDLE);
    assign op_fire   = op_valid && op_ready;
    assign res_fire  = res_valid_q && res_ready;
    assign last_pair = ((cnt_q + LEN_W'(1)) == len_q);

    bcd_word_add u_add (
        .a    (op_a),
        .b    (add_b),
        .cin  (carry_q),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cmd_fire) state_d = (cmd_len != '0) ? RUN : FIN;
            RUN:     if (op_fire && last_pair) state_d = DRAIN;
            DRAIN:   if (res_fire) state_d = FIN;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Moore-style outputs; op_ready also backs off while a result is stalled
    always_comb begin
        cmd_ready = (state_q == IDLE);
        op_ready  = (state_q == RUN) && (!res_valid_q || res_ready);
        busy      = (state_q != IDLE);
        done      = (state_q == FIN);
        psw_msk   = (state_q == FIN) ? 16'h0003 : 16'h0000;
        psw_out   = '0;
        if (state_q == FIN) begin
            psw_out[PSW_C] = carry_q;
            psw_out[PSW_Z] = zacc_q;
        end else begin
            psw_out[PSW_C] = psw_q[PSW_C];
            psw_out[PSW_Z] = psw_q[PSW_Z];
        end
    end

    // Command latch, carry/zero accumulation, result register and held PSW flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_q       <= '0;
            cnt_q       <= '0;
            sub_q       <= 1'b0;
            carry_q     <= 1'b0;
            zacc_q      <= 1'b0;
            res_data_q  <= '0;
            res_valid_q <= 1'b0;
            res_last_q  <= 1'b0;
            psw_q       <= '0;
        end else begin
            if (cmd_fire) begin
                len_q   <= cmd_len;
                sub_q   <= cmd_sub;
                carry_q <= cmd_cin;
                zacc_q  <= 1'b1;
                cnt_q   <= '0;
            end
            if (op_fire) begin
                res_data_q  <= add_sum;
                res_valid_q <= 1'b1;
                res_last_q  <= last_pair;
                carry_q     <= add_cout;
                zacc_q      <= zacc_q && (add_sum == 16'h0000);
                cnt_q       <= cnt_q + LEN_W'(1);
            end else if (res_fire) begin
                res_valid_q <= 1'b0;
            end
            if (state_q == FIN) begin
                psw_q[PSW_C] <= carry_q;
                psw_q[PSW_Z] <= zacc_q;
            end
        end
    end

    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_last  = res_last_q;

endmodule

// File: tb/tb_bcd_mp_sequencer.sv
// Randomized self-checking bench for bcd_mp_sequencer with a decimal reference model.
module tb_bcd_mp_sequencer;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_len;
    logic        cmd_sub;
    logic        cmd_cin;
    logic        op_valid;
    logic        op_ready;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_data;
    logic        res_last;
    logic        busy;
    logic        done;
    logic [15:0] psw_out;
    logic [15:0] psw_msk;

    int n_checks;
    int n_fail;

    logic [15:0] qa [8];
    logic [15:0] qb [8];
    logic [15:0] got [8];
    logic [15:0] got_psw;

    bcd_mp_sequencer #(.MAX_WORDS(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_len   (cmd_len),
        .cmd_sub   (cmd_sub),
        .cmd_cin   (cmd_cin),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_last  (res_last),
        .busy      (busy),
        .done      (done),
        .psw_out   (psw_out),
        .psw_msk   (psw_msk)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int bcd2int(input logic [15:0] w);
        return 1000 * int'(w[15:12]) + 100 * int'(w[11:8]) + 10 * int'(w[7:4]) + int'(w[3:0]);
    endfunction

    function automatic logic [15:0] int2bcd(input int v);
        logic [15:0] r;
        r[15:12] = 4'((v / 1000) % 10);
        r[11:8]  = 4'((v / 100) % 10);
        r[7:4]   = 4'((v / 10) % 10);
        r[3:0]   = 4'(v % 10);
        return r;
    endfunction

    function automatic logic [15:0] rand_bcd();
        return int2bcd(int'($urandom_range(0, 9999)));
    endfunction

    // Runs one full command; entered and left just after a rising edge
    task automatic run_cmd(input int len, input bit sub, input bit cin, input bit rnd);
        logic [15:0] exp_w [8];
        int          carry, zacc, s, bd;
        int          sent, rcv, ndone, done_cyc;
        bit          prev_stall, prev_fire, fire, rfire, seen_done;
        logic [15:0] prev_data;
        logic        prev_last;
        logic [15:0] exp_psw;

        carry = int'(cin);
        zacc  = 1;
        for (int i = 0; i < len; i++) begin
            bd       = sub ? (9999 - bcd2int(qb[i])) : bcd2int(qb[i]);
            s        = bcd2int(qa[i]) + bd + carry;
            carry    = (s >= 10000) ? 1 : 0;
            exp_w[i] = int2bcd(s % 10000);
            if ((s % 10000) != 0) zacc = 0;
        end
        exp_psw = {14'b0, zacc[0], carry[0]};

        cmd_valid = 1'b1;
        cmd_len   = 4'(len);
        cmd_sub   = sub;
        cmd_cin   = cin;
        @(negedge clk);
        n_checks++;
        if (cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL cmd_ready_idle: got %b want 1", cmd_ready);
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;

        sent = 0; rcv = 0; ndone = 0; done_cyc = 0;
        prev_stall = 0; prev_fire = 0; seen_done = 0;
        prev_data = '0; prev_last = 1'b0;
        for (int cyc = 1; cyc <= 300 && !seen_done; cyc++) begin
            op_valid  = (sent < len) && (!rnd || ($urandom_range(0, 3) != 0));
            op_a      = (sent < len) ? qa[sent] : $urandom_range(0, 65535);
            op_b      = (sent < len) ? qb[sent] : $urandom_range(0, 65535);
            res_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (prev_stall) begin
                n_checks++;
                if (res_valid !== 1'b1 || res_data !== prev_data || res_last !== prev_last) begin
                    n_fail++;
                    $display("FAIL stall_hold: got v=%b d=%h l=%b want v=1 d=%h l=%b",
                             res_valid, res_data, res_last, prev_data, prev_last);
                end
            end
            if (prev_fire) begin
                n_checks++;
                if (res_valid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL latency: res_valid got %b want 1 one cycle after accept", res_valid);
                end
            end
            if (res_valid === 1'b1 && res_ready === 1'b0) begin
                n_checks++;
                if (op_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL op_ready_stall: got %b want 0", op_ready);
                end
            end
            if (sent == len) begin
                n_checks++;
                if (op_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL op_ready_drain: got %b want 0", op_ready);
                end
            end
            if (len == 0) begin
                n_checks++;
                if (res_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL len0_no_result: res_valid got %b want 0", res_valid);
                end
            end
            n_checks++;
            if (busy !== 1'b1) begin
                n_fail++;
                $display("FAIL busy_during_cmd: got %b want 1 (cycle %0d)", busy, cyc);
            end
            if (done === 1'b1) begin
                ndone++;
                seen_done = 1;
                done_cyc  = cyc;
                got_psw   = psw_out;
                n_checks++;
                if (psw_out !== exp_psw || psw_msk !== 16'h0003) begin
                    n_fail++;
                    $display("FAIL psw_at_done: got psw=%h msk=%h want psw=%h msk=0003",
                             psw_out, psw_msk, exp_psw);
                end
                n_checks++;
                if (rcv != len) begin
                    n_fail++;
                    $display("FAIL word_count: got %0d words want %0d", rcv, len);
                end
                if (!rnd) begin
                    n_checks++;
                    if (done_cyc != ((len == 0) ? 1 : len + 2)) begin
                        n_fail++;
                        $display("FAIL throughput: done at cycle %0d want %0d",
                                 done_cyc, (len == 0) ? 1 : len + 2);
                    end
                end
            end
            fire  = (op_valid === 1'b1) && (op_ready === 1'b1);
            rfire = (res_valid === 1'b1) && (res_ready === 1'b1);
            if (rfire) begin
                n_checks++;
                if (rcv >= len) begin
                    n_fail++;
                    $display("FAIL extra_word: got %h beyond %0d words", res_data, len);
                end else if (res_data !== exp_w[rcv] || res_last !== (rcv == len - 1)) begin
                    n_fail++;
                    $display("FAIL result_word[%0d]: got d=%h l=%b want d=%h l=%b",
                             rcv, res_data, res_last, exp_w[rcv], (rcv == len - 1));
                end
                if (rcv < 8) got[rcv] = res_data;
                rcv++;
            end
            if (fire) sent++;
            prev_stall = (res_valid === 1'b1) && (res_ready === 1'b0);
            prev_data  = res_data;
            prev_last  = res_last;
            prev_fire  = fire;
            @(posedge clk);
            #1;
        end
        op_valid  = 1'b0;
        res_ready = 1'b1;
        if (!seen_done) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout: no done pulse, %0d of %0d words", rcv, len);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_checks++;
            if (done !== 1'b0 || busy !== 1'b0 || res_valid !== 1'b0 ||
                psw_msk !== 16'h0000 || psw_out !== exp_psw) begin
                n_fail++;
                $display("FAIL after_done: got done=%b busy=%b rv=%b msk=%h psw=%h want 0 0 0 0000 %h",
                         done, busy, res_valid, psw_msk, psw_out, exp_psw);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++;
        if (cmd_ready !== 1'b1 || op_ready !== 1'b0 || res_valid !== 1'b0 || res_data !== 16'h0 ||
            res_last !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || psw_out !== 16'h0 || psw_msk !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_values: got cr=%b or=%b rv=%b rd=%h rl=%b busy=%b done=%b psw=%h msk=%h",
                     cmd_ready, op_ready, res_valid, res_data, res_last, busy, done, psw_out, psw_msk);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_add_single();
        qa[0] = 16'h1234;
        qb[0] = 16'h5678;
        run_cmd(1, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (got[0] !== 16'h6912 || got_psw !== 16'h0000) begin
            n_fail++;
            $display("FAIL add_1234_5678: got %h psw=%h want 6912 psw=0000", got[0], got_psw);
        end
    endtask

    task automatic test_carry_chain();
        qa[0] = 16'h9999; qb[0] = 16'h0001;
        qa[1] = 16'h9999; qb[1] = 16'h0000;
        run_cmd(2, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (got[0] !== 16'h0000 || got[1] !== 16'h0000 || got_psw !== 16'h0003) begin
            n_fail++;
            $display("FAIL carry_chain: got %h %h psw=%h want 0000 0000 psw=0003", got[0], got[1], got_psw);
        end
    endtask

    task automatic test_sub();
        qa[0] = 16'h0050; qb[0] = 16'h0025;
        run_cmd(1, 1'b1, 1'b1, 1'b0);
        n_checks++;
        if (got[0] !== 16'h0025 || got_psw !== 16'h0001) begin
            n_fail++;
            $display("FAIL sub_no_borrow: got %h psw=%h want 0025 psw=0001", got[0], got_psw);
        end
        qa[0] = 16'h0025; qb[0] = 16'h0050;
        run_cmd(1, 1'b1, 1'b1, 1'b0);
        n_checks++;
        if (got[0] !== 16'h9975 || got_psw !== 16'h0000) begin
            n_fail++;
            $display("FAIL sub_borrow: got %h psw=%h want 9975 psw=0000", got[0], got_psw);
        end
    endtask

    task automatic test_stall_random();
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 8; i++) begin
                qa[i] = rand_bcd();
                qb[i] = rand_bcd();
            end
            run_cmd(8, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
        end
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 8; i++) begin
                qa[i] = rand_bcd();
                qb[i] = (r == 0) ? qa[i] : rand_bcd();
            end
            run_cmd(int'($urandom_range(1, 8)), (r == 0) ? 1'b1 : 1'($urandom_range(0, 1)),
                    (r == 0) ? 1'b1 : 1'($urandom_range(0, 1)), 1'b0);
        end
    endtask

    task automatic test_len0();
        run_cmd(0, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (got_psw !== 16'h0003) begin
            n_fail++;
            $display("FAIL len0_psw: got %h want 0003", got_psw);
        end
    endtask

    task automatic test_reset_mid();
        cmd_valid = 1'b1;
        cmd_len   = 4'd8;
        cmd_sub   = 1'b0;
        cmd_cin   = 1'b0;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        op_valid  = 1'b1;
        res_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            op_a = rand_bcd();
            op_b = 16'h0001;
            @(posedge clk);
            #1;
        end
        n_checks++;
        if (res_valid !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_stream: got rv=%b busy=%b want 1 1", res_valid, busy);
        end
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (cmd_ready !== 1'b1 || op_ready !== 1'b0 || res_valid !== 1'b0 || res_data !== 16'h0 ||
            res_last !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || psw_out !== 16'h0 || psw_msk !== 16'h0) begin
            n_fail++;
            $display("FAIL async_reset: got cr=%b or=%b rv=%b rd=%h rl=%b busy=%b done=%b psw=%h msk=%h",
                     cmd_ready, op_ready, res_valid, res_data, res_last, busy, done, psw_out, psw_msk);
        end
        op_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_checks++;
            if (cmd_ready !== 1'b1 || done !== 1'b0 || res_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL post_reset: got cr=%b done=%b rv=%b want 1 0 0", cmd_ready, done, res_valid);
            end
            @(posedge clk);
            #1;
        end
        qa[0] = 16'h0001;
        qb[0] = 16'h0002;
        run_cmd(1, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (got[0] !== 16'h0003) begin
            n_fail++;
            $display("FAIL after_reset_cmd: got %h want 0003", got[0]);
        end
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_len   = '0;
        cmd_sub   = 1'b0;
        cmd_cin   = 1'b0;
        op_valid  = 1'b0;
        op_a      = '0;
        op_b      = '0;
        res_ready = 1'b1;
        got_psw   = '0;
        for (int i = 0; i < 8; i++) begin
            qa[i]  = '0;
            qb[i]  = '0;
            got[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        test_reset();
        test_add_single();
        test_carry_chain();
        test_sub();
        test_stall_random();
        test_back_to_back();
        test_len0();
        test_reset_mid();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
